// File: rtl/cache_write_buffer.sv
// rtl/cache_write_buffer.sv - coalescing eviction write buffer draining dirty lines to memory
module cache_write_buffer #(
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_WIDTH   = 128,
    parameter int OFFSET_WIDTH = 4,
    parameter int DEPTH        = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_buffer_en,
    input  logic [ADDR_WIDTH-1:0] addr_to_write_buffer,
    input  logic [LINE_WIDTH-1:0] data_to_write_buffer,
    output logic                  wb_full,
    output logic                  wb_empty,
    output logic                  wb_overflow,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  lookup_hit,
    output logic [LINE_WIDTH-1:0] lookup_data,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_wr_addr,
    output logic [LINE_WIDTH-1:0] mem_wr_data,
    input  logic                  mem_wr_ready
);
    localparam int LINE_AW = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    typedef enum logic {S_IDLE, S_REQ} state_t;

    logic [LINE_AW-1:0]    line_q [DEPTH];
    logic [LINE_WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0]      valid_q;
    logic [PTR_W-1:0]      head_q, tail_q;
    logic [CNT_W-1:0]      count_q, count_d;
    state_t                state_q;
    logic                  mem_wr_en_q;
    logic [ADDR_WIDTH-1:0] mem_wr_addr_q;
    logic [LINE_WIDTH-1:0] mem_wr_data_q;
    logic                  overflow_q;

    logic [LINE_AW-1:0]    push_line, look_line;
    logic                  transfer, in_flight, full;
    logic                  coal_hit, do_coal, do_alloc, do_drop;
    logic [PTR_W-1:0]      coal_idx;
    logic [LINE_WIDTH-1:0] head_data;
    logic                  unused_offsets;

    assign push_line = addr_to_write_buffer[ADDR_WIDTH-1:OFFSET_WIDTH];
    assign look_line = lookup_addr[ADDR_WIDTH-1:OFFSET_WIDTH];
    assign unused_offsets = ^{addr_to_write_buffer[OFFSET_WIDTH-1:0], lookup_addr[OFFSET_WIDTH-1:0]};
    assign transfer  = mem_wr_en_q & mem_wr_ready;
    assign in_flight = (state_q == S_REQ);
    assign full      = (count_q == CNT_W'(DEPTH));

    // Find a pending (not in-flight) entry holding the pushed line
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && line_q[i] == push_line && !(in_flight && PTR_W'(i) == head_q)) begin
                coal_hit = 1'b1;
                coal_idx = PTR_W'(i);
            end
        end
    end

    assign do_coal  = write_buffer_en & coal_hit;
    assign do_alloc = write_buffer_en & ~coal_hit & (~full | transfer);
    assign do_drop  = write_buffer_en & ~coal_hit & full & ~transfer;
    assign count_d  = count_q + CNT_W'(do_alloc) - CNT_W'(transfer);

    // Forward a same-edge coalesce into the head so the captured request carries the newest data
    assign head_data = (do_coal && coal_idx == head_q) ? data_to_write_buffer : data_q[head_q];

    // Refill lookup; a newer pending copy of a line beats the in-flight copy
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        if (in_flight && valid_q[head_q] && line_q[head_q] == look_line) begin
            lookup_hit  = 1'b1;
            lookup_data = data_q[head_q];
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && line_q[i] == look_line && !(in_flight && PTR_W'(i) == head_q)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[i];
            end
        end
    end

    // Line address/data storage: coalesce overwrites in place, allocation writes the tail
    always_ff @(posedge clk) begin
        if (do_coal) begin
            data_q[coal_idx] <= data_to_write_buffer;
        end
        if (do_alloc) begin
            line_q[tail_q] <= push_line;
            data_q[tail_q] <= data_to_write_buffer;
        end
    end

    // Queue bookkeeping, drain FSM with registered memory request, sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            mem_wr_en_q   <= 1'b0;
            mem_wr_addr_q <= '0;
            mem_wr_data_q <= '0;
            overflow_q    <= 1'b0;
        end else begin
            if (transfer) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= head_q + 1'b1;
            end
            if (do_alloc) begin
                valid_q[tail_q] <= 1'b1;
                tail_q          <= tail_q + 1'b1;
            end
            count_q <= count_d;
            if (do_drop) begin
                overflow_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (count_q != '0) begin
                        state_q       <= S_REQ;
                        mem_wr_en_q   <= 1'b1;
                        mem_wr_addr_q <= {line_q[head_q], {OFFSET_WIDTH{1'b0}}};
                        mem_wr_data_q <= head_data;
                    end
                end
                S_REQ: begin
                    if (transfer) begin
                        state_q     <= S_IDLE;
                        mem_wr_en_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign wb_full     = full;
    assign wb_empty    = (count_q == '0);
    assign wb_overflow = overflow_q;
    assign mem_wr_en   = mem_wr_en_q;
    assign mem_wr_addr = mem_wr_addr_q;
    assign mem_wr_data = mem_wr_data_q;
endmodule
